// File: rtl/lc3b_types.sv
// lc3b_types: shared BTB types and saturating-counter constants.
//   lc3b_word  16-bit machine word
//   btb_entry  one way of a BTB set: valid, tag, target, 2-bit counter
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  // widest tag any legal NUM_SETS can produce (NUM_SETS=2); narrower tags are zero-extended
  localparam int TAG_MAX = 14;
  localparam logic [1:0] CTR_STEP = 2'b01;
  localparam logic [1:0] CTR_MAX = 2'b11;
  localparam logic [1:0] CTR_MIN = 2'b00;
  localparam logic [1:0] CTR_INIT_T = 2'b10;
  localparam logic [1:0] CTR_INIT_NT = 2'b01;
  typedef struct packed {
    logic valid;
    logic [TAG_MAX-1:0] tag;
    lc3b_word target;
    logic [1:0] counter;
  } btb_entry;
endpackage

// File: rtl/btb_counter.sv
// btb_counter: 2-bit saturating direction counter update.
//   ctr_i    current counter
//   taken_i  resolved direction (1 = count up, 0 = count down)
//   ctr_o    updated counter, saturating at 2'b11 / 2'b00
module btb_counter
  import lc3b_types::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);
  always_comb begin
    ctr_o = taken_i ? ((ctr_i == CTR_MAX) ? ctr_i : ctr_i + CTR_STEP)
                    : ((ctr_i == CTR_MIN) ? ctr_i : ctr_i - CTR_STEP);
  end
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: 2-way set-associative BTB with per-set LRU and 2-bit counters.
//   clk, rst_n                      clock, async active-low reset
//   stall, fetch_valid, fetch_pc    lookup request (accepted when fetch_valid & !stall)
//   pred_valid/hit/taken/target     registered prediction for the previous accepted lookup
//   load_btb, upd_pc/target/taken   resolved-branch write (update on hit, allocate on miss)
//   flush_btb                       invalidate all entries and LRU bits
module branch_target_buffer
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8,
  parameter int TAG_W = 16 - 1 - $clog2(NUM_SETS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        fetch_valid,
  input  logic [15:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [15:0] pred_target,
  input  logic        load_btb,
  input  logic [15:0] upd_pc,
  input  logic [15:0] upd_target,
  input  logic        upd_taken,
  input  logic        flush_btb
);
  localparam int IW = $clog2(NUM_SETS);
  btb_entry mem_q [NUM_SETS][2];
  logic [NUM_SETS-1:0] lru_q;
  logic [IW-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  btb_entry f0, f1, u0, u1, u_new;
  logic f_hit0, f_hit1, f_hit, u_hit0, u_hit1, u_way;
  logic [1:0] u_ctr_old, u_ctr_next;
  logic unused;
  assign unused = fetch_pc[0] ^ upd_pc[0];
  assign f_idx = fetch_pc[IW:1];
  assign f_tag = fetch_pc[15:IW+1];
  assign u_idx = upd_pc[IW:1];
  assign u_tag = upd_pc[15:IW+1];
  assign f0 = mem_q[f_idx][0];
  assign f1 = mem_q[f_idx][1];
  assign u0 = mem_q[u_idx][0];
  assign u1 = mem_q[u_idx][1];
  assign f_hit0 = f0.valid && f0.tag == TAG_MAX'(f_tag);
  assign f_hit1 = f1.valid && f1.tag == TAG_MAX'(f_tag);
  assign f_hit = f_hit0 | f_hit1;
  assign u_hit0 = u0.valid && u0.tag == TAG_MAX'(u_tag);
  assign u_hit1 = u1.valid && u1.tag == TAG_MAX'(u_tag);
  // hit way first, then first invalid way, then the LRU way
  assign u_way = u_hit1 ? 1'b1 : u_hit0 ? 1'b0 : !u0.valid ? 1'b0 : !u1.valid ? 1'b1 : lru_q[u_idx];
  assign u_ctr_old = u_way ? u1.counter : u0.counter;
  btb_counter u_ctr (
    .ctr_i  (u_ctr_old),
    .taken_i(upd_taken),
    .ctr_o  (u_ctr_next)
  );
  always_comb begin
    u_new.valid = 1'b1;
    u_new.tag = TAG_MAX'(u_tag);
    u_new.target = upd_target;
    u_new.counter = (u_hit0 | u_hit1) ? u_ctr_next : (upd_taken ? CTR_INIT_T : CTR_INIT_NT);
  end
  // lookup reads pre-edge contents, so a same-cycle load/flush is invisible to it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        mem_q[i][0].valid <= 1'b0;
        mem_q[i][1].valid <= 1'b0;
      end
      lru_q <= '0;
      pred_valid <= 1'b0;
      pred_hit <= 1'b0;
      pred_taken <= 1'b0;
      pred_target <= '0;
    end else begin
      if (!stall) begin
        pred_valid <= fetch_valid;
        pred_hit <= fetch_valid && f_hit;
        pred_taken <= fetch_valid && f_hit && (f_hit1 ? f1.counter[1] : f0.counter[1]);
        pred_target <= (fetch_valid && f_hit) ? (f_hit1 ? f1.target : f0.target) : '0;
      end
      if (flush_btb) begin
        for (int i = 0; i < NUM_SETS; i++) begin
          mem_q[i][0].valid <= 1'b0;
          mem_q[i][1].valid <= 1'b0;
        end
        lru_q <= '0;
      end else begin
        if (fetch_valid && !stall && f_hit) lru_q[f_idx] <= !f_hit1;
        // later assignment: the load's LRU update wins over the lookup's
        if (load_btb) begin
          mem_q[u_idx][u_way] <= u_new;
          lru_q[u_idx] <= !u_way;
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed table, hand sequences and random stimulus vs. a reference model.
module tb_branch_target_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0, fetch_valid = 1'b0, load_btb = 1'b0, upd_taken = 1'b0, flush_btb = 1'b0;
  logic [15:0] fetch_pc = '0, upd_pc = '0, upd_target = '0;
  logic pred_valid, pred_hit, pred_taken;
  logic [15:0] pred_target;
  int checks = 0;
  int fails = 0;

  branch_target_buffer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .load_btb(load_btb), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .flush_btb(flush_btb)
  );

  always #5 clk = ~clk;

  // reference model: NUM_SETS=8, set = pc[3:1], tag = pc[15:4]
  int m_valid [8][2];
  int m_tag [8][2];
  int m_tgt [8][2];
  int m_ctr [8][2];
  int m_lru [8];
  logic [18:0] m_pred;

  typedef struct {
    logic fv, st;
    logic [15:0] pc;
    logic ld;
    logic [15:0] upc, utgt;
    logic utk, fl;
    logic [18:0] exp;
  } vec_t;
  vec_t tbl [$];

  function automatic logic [18:0] dut_pred();
    return {pred_valid, pred_hit, pred_taken, pred_target};
  endfunction

  task automatic chk(input string nm, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got valid=%0b hit=%0b taken=%0b target=%h, expected valid=%0b hit=%0b taken=%0b target=%h",
               nm, act[18], act[17], act[16], act[15:0], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < 8; s++) begin
      m_valid[s][0] = 0;
      m_valid[s][1] = 0;
      m_lru[s] = 0;
    end
  endfunction

  function automatic void model_step(input logic fv, st, input logic [15:0] pc, input logic ld,
                                     input logic [15:0] upc, utgt, input logic utk, fl);
    int s, t, hw, us, ut, uw;
    bit uhit;
    s = int'(pc[3:1]);
    t = int'(pc[15:4]);
    us = int'(upc[3:1]);
    ut = int'(upc[15:4]);
    hw = -1;
    uw = -1;
    for (int w = 0; w < 2; w++) begin
      if (m_valid[s][w] != 0 && m_tag[s][w] == t) hw = w;
      if (m_valid[us][w] != 0 && m_tag[us][w] == ut) uw = w;
    end
    uhit = uw >= 0;
    if (!uhit) uw = (m_valid[us][0] == 0) ? 0 : (m_valid[us][1] == 0) ? 1 : m_lru[us];
    if (!st) begin
      if (fv && hw >= 0) m_pred = {1'b1, 1'b1, m_ctr[s][hw] >= 2, 16'(m_tgt[s][hw])};
      else m_pred = {fv, 18'b0};
    end
    if (fl) model_clear();
    else begin
      if (!st && fv && hw >= 0) m_lru[s] = 1 - hw;
      if (ld) begin
        if (uhit) m_ctr[us][uw] = utk ? ((m_ctr[us][uw] < 3) ? m_ctr[us][uw] + 1 : 3)
                                      : ((m_ctr[us][uw] > 0) ? m_ctr[us][uw] - 1 : 0);
        else m_ctr[us][uw] = utk ? 2 : 1;
        m_valid[us][uw] = 1;
        m_tag[us][uw] = ut;
        m_tgt[us][uw] = int'(utgt);
        m_lru[us] = 1 - uw;
      end
    end
  endfunction

  task automatic cycle(input logic fv, st, input logic [15:0] pc, input logic ld,
                       input logic [15:0] upc, utgt, input logic utk, fl, input string nm);
    fetch_valid = fv;
    stall = st;
    fetch_pc = pc;
    load_btb = ld;
    upd_pc = upc;
    upd_target = utgt;
    upd_taken = utk;
    flush_btb = fl;
    model_step(fv, st, pc, ld, upc, utgt, utk, fl);
    @(posedge clk);
    #1;
    chk(nm, dut_pred(), m_pred);
  endtask

  function automatic vec_t mk(input logic fv, input logic [15:0] pc, input logic ld,
                              input logic [15:0] upc, utgt, input logic utk, input logic [18:0] exp);
    vec_t v;
    v.fv = fv; v.st = 1'b0; v.pc = pc; v.ld = ld; v.upc = upc; v.utgt = utgt;
    v.utk = utk; v.fl = 1'b0; v.exp = exp;
    return v;
  endfunction

  initial begin
    tbl.push_back(mk(1, 16'h3000, 0, 0, 0, 0, {3'b100, 16'h0000}));
    tbl.push_back(mk(0, 0, 1, 16'h3004, 16'h3100, 1, 19'h0));
    tbl.push_back(mk(1, 16'h3004, 0, 0, 0, 0, {3'b111, 16'h3100}));
    tbl.push_back(mk(0, 0, 1, 16'h3002, 16'h1111, 1, 19'h0));
    tbl.push_back(mk(0, 0, 1, 16'h3012, 16'h2222, 0, 19'h0));
    tbl.push_back(mk(1, 16'h3002, 0, 0, 0, 0, {3'b111, 16'h1111}));
    tbl.push_back(mk(0, 0, 1, 16'h3022, 16'h3333, 1, 19'h0));
    tbl.push_back(mk(1, 16'h3012, 0, 0, 0, 0, {3'b100, 16'h0000}));
    tbl.push_back(mk(1, 16'h3002, 0, 0, 0, 0, {3'b111, 16'h1111}));
    tbl.push_back(mk(1, 16'h3022, 0, 0, 0, 0, {3'b111, 16'h3333}));
    tbl.push_back(mk(0, 0, 1, 16'h3004, 16'h3100, 0, 19'h0));
    tbl.push_back(mk(0, 0, 1, 16'h3004, 16'h3100, 0, 19'h0));
    tbl.push_back(mk(1, 16'h3004, 0, 0, 0, 0, {3'b110, 16'h3100}));
    tbl.push_back(mk(0, 0, 1, 16'h3004, 16'h3100, 1, 19'h0));
    tbl.push_back(mk(0, 0, 1, 16'h3004, 16'h3100, 1, 19'h0));
    tbl.push_back(mk(0, 0, 1, 16'h3004, 16'h3100, 1, 19'h0));
    tbl.push_back(mk(1, 16'h3004, 1, 16'h3004, 16'h3100, 1, {3'b111, 16'h3100}));
    tbl.push_back(mk(0, 0, 1, 16'h3004, 16'h3100, 0, 19'h0));
    tbl.push_back(mk(1, 16'h3004, 0, 0, 0, 0, {3'b111, 16'h3100}));
    tbl.push_back(mk(1, 16'h3006, 1, 16'h3006, 16'h3600, 1, {3'b100, 16'h0000}));
    tbl.push_back(mk(1, 16'h3006, 0, 0, 0, 0, {3'b111, 16'h3600}));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 19'h0));

    #1;
    chk("reset_state", dut_pred(), 19'h0);
    model_clear();
    m_pred = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].fv, tbl[i].st, tbl[i].pc, tbl[i].ld, tbl[i].upc, tbl[i].utgt, tbl[i].utk, tbl[i].fl, "table_model");
      chk($sformatf("table_%0d", i), dut_pred(), tbl[i].exp);
    end

    cycle(1, 0, 16'h3002, 0, 0, 0, 0, 0, "pre_stall");
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 16'h3000, 0, 0, 0, 0, 0, "stall_model");
      chk($sformatf("stall_hold_%0d", i), dut_pred(), {3'b111, 16'h1111});
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "idle_after_stall");

    cycle(1, 0, 16'h3002, 1, 16'h3008, 16'h3800, 1, 1, "flush_model");
    chk("flush_same_cycle_lookup", dut_pred(), {3'b111, 16'h1111});
    cycle(1, 0, 16'h3002, 0, 0, 0, 0, 0, "post_flush_model");
    chk("post_flush_3002", dut_pred(), {3'b100, 16'h0});
    cycle(1, 0, 16'h3008, 0, 0, 0, 0, 0, "post_flush_model");
    chk("flush_drops_load_3008", dut_pred(), {3'b100, 16'h0});
    cycle(1, 0, 16'h3004, 0, 0, 0, 0, 0, "post_flush_model");
    chk("post_flush_3004", dut_pred(), {3'b100, 16'h0});

    cycle(0, 0, 0, 1, 16'h3002, 16'h1111, 1, 0, "reload");
    cycle(1, 0, 16'h3002, 0, 0, 0, 0, 0, "pre_reset_hit");
    fetch_valid = 1'b1;
    fetch_pc = 16'h3002;
    load_btb = 1'b1;
    upd_pc = 16'h3014;
    rst_n = 1'b0;
    #2;
    chk("reset_async_drop", dut_pred(), 19'h0);
    model_clear();
    m_pred = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1, 0, 16'h3002, 0, 0, 0, 0, 0, "post_reset_model");
    chk("post_reset_3002", dut_pred(), {3'b100, 16'h0});
    cycle(1, 0, 16'h3014, 0, 0, 0, 0, 0, "post_reset_model");
    chk("post_reset_inflight_load", dut_pred(), {3'b100, 16'h0});

    for (int i = 0; i < 400; i++) begin
      logic [15:0] pc, upc;
      pc = 16'h3000 | 16'($urandom_range(0, 3) << 4) | 16'($urandom_range(0, 3) << 1) | 16'($urandom_range(0, 1));
      upc = 16'h3000 | 16'($urandom_range(0, 3) << 4) | 16'($urandom_range(0, 3) << 1) | 16'($urandom_range(0, 1));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, pc, $urandom_range(0, 9) < 4,
            upc, 16'($urandom), 1'($urandom), $urandom_range(0, 39) == 0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
